// File: rtl/lc3_control_fsm.sv
// Instruction-sequencing controller for the LC-3 subset datapath: a Moore FSM that walks
// fetch, decode and execute, and is the sole driver of every datapath load, gate, select and strobe.
module lc3_control_fsm #(
   parameter int unsigned MEM_WAIT = 2
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       run_i,
   input  logic       continue_i,
   input  logic [3:0] opcode_i,
   input  logic       ir_5_i,
   input  logic       ben_i,
   output logic       ld_mar_o,
   output logic       ld_mdr_o,
   output logic       ld_ir_o,
   output logic       ld_ben_o,
   output logic       ld_cc_o,
   output logic       ld_reg_o,
   output logic       ld_pc_o,
   output logic       ld_led_o,
   output logic       gate_pc_o,
   output logic       gate_mdr_o,
   output logic       gate_alu_o,
   output logic       gate_marmux_o,
   output logic [1:0] pcmux_o,
   output logic [1:0] addr2mux_o,
   output logic [1:0] aluk_o,
   output logic       drmux_o,
   output logic       sr1mux_o,
   output logic       sr2mux_o,
   output logic       addr1mux_o,
   output logic       mio_en_o,
   output logic       mem_oe_o,
   output logic       mem_we_o
);

   localparam logic [3:0] OP_BR    = 4'b0000;
   localparam logic [3:0] OP_ADD   = 4'b0001;
   localparam logic [3:0] OP_JSR   = 4'b0100;
   localparam logic [3:0] OP_AND   = 4'b0101;
   localparam logic [3:0] OP_LDR   = 4'b0110;
   localparam logic [3:0] OP_STR   = 4'b0111;
   localparam logic [3:0] OP_NOT   = 4'b1001;
   localparam logic [3:0] OP_JMP   = 4'b1100;
   localparam logic [3:0] OP_PAUSE = 4'b1101;

   localparam logic [1:0] PCMUX_ADDR = 2'd1;
   localparam logic [1:0] PCMUX_INC  = 2'd2;
   localparam logic [1:0] A2_OFF9    = 2'd1;
   localparam logic [1:0] A2_OFF6    = 2'd2;
   localparam logic [1:0] A2_ZERO    = 2'd3;
   localparam logic [1:0] ALU_AND    = 2'd1;
   localparam logic [1:0] ALU_NOT    = 2'd2;
   localparam logic [1:0] ALU_PASSA  = 2'd3;

   localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT - 1);

   typedef enum logic [4:0] {
      ST_HALTED, ST_S18, ST_S33, ST_S35, ST_S32,
      ST_S01, ST_S05, ST_S09, ST_S00, ST_S22,
      ST_S12, ST_S04, ST_S21, ST_S06, ST_S25,
      ST_S27, ST_S07, ST_S23, ST_S16, ST_PAUSE1,
      ST_PAUSE2
   } state_e;

   state_e     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic       wait_done;

   assign wait_done = (cnt_q == WAIT_LAST);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= ST_HALTED;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      // NOTE: every combinational output gets a default first, so no path can infer a latch.
      state_d = state_q;
      case (state_q)
         ST_HALTED: if (run_i) state_d = ST_S18;
         ST_S18:    state_d = ST_S33;
         ST_S33:    if (wait_done) state_d = ST_S35;
         ST_S35:    state_d = ST_S32;
         ST_S32: begin
            case (opcode_i)
               OP_ADD:   state_d = ST_S01;
               OP_AND:   state_d = ST_S05;
               OP_NOT:   state_d = ST_S09;
               OP_BR:    state_d = ST_S00;
               OP_JMP:   state_d = ST_S12;
               OP_JSR:   state_d = ST_S04;
               OP_LDR:   state_d = ST_S06;
               OP_STR:   state_d = ST_S07;
               OP_PAUSE: state_d = ST_PAUSE1;
               default:  state_d = ST_S18;
            endcase
         end
         ST_S00:    state_d = ben_i ? ST_S22 : ST_S18;
         ST_S04:    state_d = ST_S21;
         ST_S06:    state_d = ST_S25;
         ST_S25:    if (wait_done) state_d = ST_S27;
         ST_S07:    state_d = ST_S23;
         ST_S23:    state_d = ST_S16;
         ST_S16:    if (wait_done) state_d = ST_S18;
         ST_PAUSE1: if (continue_i) state_d = ST_PAUSE2;
         ST_PAUSE2: if (!continue_i) state_d = ST_S18;
         ST_S01, ST_S05, ST_S09, ST_S22, ST_S12, ST_S21, ST_S27: state_d = ST_S18;
         default:   state_d = ST_HALTED;
      endcase

      // The counter restarts at zero whenever a state is entered; in PAUSE1 it only marks "not first cycle".
      cnt_d = '0;
      if (state_d == state_q) begin
         case (state_q)
            ST_S33, ST_S25, ST_S16: cnt_d = cnt_q + 4'd1;
            ST_PAUSE1:              cnt_d = 4'd1;
            default:                cnt_d = '0;
         endcase
      end
   end

   always_comb begin
      ld_mar_o      = 1'b0;
      ld_mdr_o      = 1'b0;
      ld_ir_o       = 1'b0;
      ld_ben_o      = 1'b0;
      ld_cc_o       = 1'b0;
      ld_reg_o      = 1'b0;
      ld_pc_o       = 1'b0;
      ld_led_o      = 1'b0;
      gate_pc_o     = 1'b0;
      gate_mdr_o    = 1'b0;
      gate_alu_o    = 1'b0;
      gate_marmux_o = 1'b0;
      pcmux_o       = 2'd0;
      addr2mux_o    = 2'd0;
      aluk_o        = 2'd0;
      drmux_o       = 1'b0;
      sr1mux_o      = 1'b0;
      sr2mux_o      = 1'b0;
      addr1mux_o    = 1'b0;
      mio_en_o      = 1'b0;
      mem_oe_o      = 1'b1;
      mem_we_o      = 1'b1;
      case (state_q)
         ST_S18: begin
            gate_pc_o = 1'b1;
            ld_mar_o  = 1'b1;
            pcmux_o   = PCMUX_INC;
            ld_pc_o   = 1'b1;
         end
         ST_S33, ST_S25: begin
            mem_oe_o = 1'b0;
            mio_en_o = 1'b1;
            ld_mdr_o = 1'b1;
         end
         ST_S35: begin
            gate_mdr_o = 1'b1;
            ld_ir_o    = 1'b1;
         end
         ST_S32: ld_ben_o = 1'b1;
         // IR_5 is an IR register bit, so the SR2 select still follows registered state.
         ST_S01, ST_S05, ST_S09: begin
            sr1mux_o   = 1'b1;
            gate_alu_o = 1'b1;
            ld_reg_o   = 1'b1;
            ld_cc_o    = 1'b1;
            if (state_q != ST_S09) sr2mux_o = ~ir_5_i;
            if (state_q == ST_S05) aluk_o = ALU_AND;
            if (state_q == ST_S09) aluk_o = ALU_NOT;
         end
         ST_S22: begin
            addr1mux_o = 1'b1;
            addr2mux_o = A2_OFF9;
            pcmux_o    = PCMUX_ADDR;
            ld_pc_o    = 1'b1;
         end
         ST_S12: begin
            sr1mux_o   = 1'b1;
            addr2mux_o = A2_ZERO;
            pcmux_o    = PCMUX_ADDR;
            ld_pc_o    = 1'b1;
         end
         ST_S04: begin
            drmux_o   = 1'b1;
            gate_pc_o = 1'b1;
            ld_reg_o  = 1'b1;
         end
         ST_S21: begin
            addr1mux_o = 1'b1;
            pcmux_o    = PCMUX_ADDR;
            ld_pc_o    = 1'b1;
         end
         ST_S06, ST_S07: begin
            sr1mux_o      = 1'b1;
            addr2mux_o    = A2_OFF6;
            gate_marmux_o = 1'b1;
            ld_mar_o      = 1'b1;
         end
         ST_S27: begin
            gate_mdr_o = 1'b1;
            ld_reg_o   = 1'b1;
            ld_cc_o    = 1'b1;
         end
         ST_S23: begin
            aluk_o     = ALU_PASSA;
            gate_alu_o = 1'b1;
            ld_mdr_o   = 1'b1;
         end
         ST_S16:    mem_we_o = 1'b0;
         ST_PAUSE1: ld_led_o = (cnt_q == 4'd0);
         default: ;
      endcase
   end

endmodule

// File: tb/tb_lc3_control_fsm.sv
// Bench for lc3_control_fsm: two instances (MEM_WAIT 2 and 3), each checked cycle by cycle
// against per-instruction control-word sequences built from the instruction set description.
module tb_lc3_control_fsm;

   typedef struct packed {
      logic       ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
      logic       gate_pc, gate_mdr, gate_alu, gate_marmux;
      logic [1:0] pcmux, addr2mux, aluk;
      logic       drmux, sr1mux, sr2mux, addr1mux, mio_en, mem_oe, mem_we;
   } ctl_t;

   localparam logic [3:0] OP_PAUSE = 4'b1101;

   logic       clk = 1'b0;
   logic [1:0] rst = 2'b11;
   logic       run = 1'b0;
   logic       cont = 1'b0;
   logic [3:0] opcode = 4'd0;
   logic       ir5 = 1'b0;
   logic       ben = 1'b0;

   wire [1:0] ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
   wire [1:0] gate_pc, gate_mdr, gate_alu, gate_marmux;
   wire [1:0] drmux, sr1mux, sr2mux, addr1mux, mio_en, mem_oe, mem_we;
   wire [1:0] pcmux [2];
   wire [1:0] addr2mux [2];
   wire [1:0] aluk [2];

   int   checks = 0;
   int   errors = 0;
   int   sel = 0;
   bit   noisy_run = 1'b0;
   ctl_t exp_q[$];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : gen_dut
      lc3_control_fsm #(.MEM_WAIT(g + 2)) u_dut (
         .clk_i        (clk),
         .reset_i      (rst[g]),
         .run_i        (run),
         .continue_i   (cont),
         .opcode_i     (opcode),
         .ir_5_i       (ir5),
         .ben_i        (ben),
         .ld_mar_o     (ld_mar[g]),
         .ld_mdr_o     (ld_mdr[g]),
         .ld_ir_o      (ld_ir[g]),
         .ld_ben_o     (ld_ben[g]),
         .ld_cc_o      (ld_cc[g]),
         .ld_reg_o     (ld_reg[g]),
         .ld_pc_o      (ld_pc[g]),
         .ld_led_o     (ld_led[g]),
         .gate_pc_o    (gate_pc[g]),
         .gate_mdr_o   (gate_mdr[g]),
         .gate_alu_o   (gate_alu[g]),
         .gate_marmux_o(gate_marmux[g]),
         .pcmux_o      (pcmux[g]),
         .addr2mux_o   (addr2mux[g]),
         .aluk_o       (aluk[g]),
         .drmux_o      (drmux[g]),
         .sr1mux_o     (sr1mux[g]),
         .sr2mux_o     (sr2mux[g]),
         .addr1mux_o   (addr1mux[g]),
         .mio_en_o     (mio_en[g]),
         .mem_oe_o     (mem_oe[g]),
         .mem_we_o     (mem_we[g])
      );
   end

   function automatic ctl_t observed(int g);
      ctl_t c;
      c.ld_mar = ld_mar[g];   c.ld_mdr = ld_mdr[g];     c.ld_ir = ld_ir[g];       c.ld_ben = ld_ben[g];
      c.ld_cc = ld_cc[g];     c.ld_reg = ld_reg[g];     c.ld_pc = ld_pc[g];       c.ld_led = ld_led[g];
      c.gate_pc = gate_pc[g]; c.gate_mdr = gate_mdr[g]; c.gate_alu = gate_alu[g]; c.gate_marmux = gate_marmux[g];
      c.pcmux = pcmux[g];     c.addr2mux = addr2mux[g]; c.aluk = aluk[g];
      c.drmux = drmux[g];     c.sr1mux = sr1mux[g];     c.sr2mux = sr2mux[g];     c.addr1mux = addr1mux[g];
      c.mio_en = mio_en[g];   c.mem_oe = mem_oe[g];     c.mem_we = mem_we[g];
      return c;
   endfunction

   function automatic ctl_t dflt();
      ctl_t c = '0;
      c.mem_oe = 1'b1;
      c.mem_we = 1'b1;
      return c;
   endfunction

   function automatic ctl_t mem_read();
      ctl_t c = dflt();
      c.mem_oe = 1'b0;
      c.mio_en = 1'b1;
      c.ld_mdr = 1'b1;
      return c;
   endfunction

   function automatic ctl_t addr_calc();
      ctl_t c = dflt();
      c.sr1mux = 1'b1;
      c.addr2mux = 2'd2;
      c.gate_marmux = 1'b1;
      c.ld_mar = 1'b1;
      return c;
   endfunction

   // Fetch: PC to MAR and PC+1, MEM_WAIT read cycles, MDR to IR, then the decode cycle.
   task automatic push_fetch(int mw);
      ctl_t c = dflt();
      c.gate_pc = 1'b1; c.ld_mar = 1'b1; c.pcmux = 2'd2; c.ld_pc = 1'b1;
      exp_q.push_back(c);
      repeat (mw) exp_q.push_back(mem_read());
      c = dflt(); c.gate_mdr = 1'b1; c.ld_ir = 1'b1;
      exp_q.push_back(c);
      c = dflt(); c.ld_ben = 1'b1;
      exp_q.push_back(c);
   endtask

   task automatic push_exec(logic [3:0] op, bit i5, bit b, int mw);
      ctl_t c = dflt();
      case (op)
         4'b0001, 4'b0101, 4'b1001: begin
            c.sr1mux = 1'b1; c.gate_alu = 1'b1; c.ld_reg = 1'b1; c.ld_cc = 1'b1;
            c.sr2mux = (op == 4'b1001) ? 1'b0 : ~i5;
            c.aluk = (op == 4'b0001) ? 2'd0 : (op == 4'b0101) ? 2'd1 : 2'd2;
            exp_q.push_back(c);
         end
         4'b0000: begin
            exp_q.push_back(c);
            if (b) begin
               c.addr1mux = 1'b1; c.addr2mux = 2'd1; c.pcmux = 2'd1; c.ld_pc = 1'b1;
               exp_q.push_back(c);
            end
         end
         4'b1100: begin
            c.sr1mux = 1'b1; c.addr2mux = 2'd3; c.pcmux = 2'd1; c.ld_pc = 1'b1;
            exp_q.push_back(c);
         end
         4'b0100: begin
            c.drmux = 1'b1; c.gate_pc = 1'b1; c.ld_reg = 1'b1;
            exp_q.push_back(c);
            c = dflt(); c.addr1mux = 1'b1; c.pcmux = 2'd1; c.ld_pc = 1'b1;
            exp_q.push_back(c);
         end
         4'b0110: begin
            exp_q.push_back(addr_calc());
            repeat (mw) exp_q.push_back(mem_read());
            c.gate_mdr = 1'b1; c.ld_reg = 1'b1; c.ld_cc = 1'b1;
            exp_q.push_back(c);
         end
         4'b0111: begin
            exp_q.push_back(addr_calc());
            c.aluk = 2'd3; c.gate_alu = 1'b1; c.ld_mdr = 1'b1;
            exp_q.push_back(c);
            c = dflt(); c.mem_we = 1'b0;
            repeat (mw) exp_q.push_back(c);
         end
         default: ;
      endcase
   endtask

   // Compare the visible control word of the active instance, then advance one clock.
   task automatic check_cycle(string tag);
      ctl_t exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : dflt();
      ctl_t obs_w = observed(sel);
      int   gates = $countones({obs_w.gate_pc, obs_w.gate_mdr, obs_w.gate_alu, obs_w.gate_marmux});
      checks++;
      assert (obs_w === exp_w) else begin
         errors++;
         $error("FAIL %s obs=%h exp=%h", tag, obs_w, exp_w);
      end
      checks++;
      assert (gates <= 1) else begin
         errors++;
         $error("FAIL %s_bus_gates obs=%0d exp<=1", tag, gates);
      end
      if (noisy_run) run = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
   endtask

   task automatic run_n(int n, string tag);
      for (int i = 0; i < n; i++) check_cycle($sformatf("%s[%0d]", tag, i));
   endtask

   task automatic run_queue(string tag);
      run_n(exp_q.size(), tag);
   endtask

   task automatic run_pulse();
      run = 1'b0;
      exp_q.push_back(dflt());
      check_cycle("halted_idle");
      run = 1'b1;
      exp_q.push_back(dflt());
      check_cycle("halted_run");
      run = 1'b0;
   endtask

   task automatic start(int g);
      rst = 2'b11;
      run = 1'b0;
      cont = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst[g] = 1'b0;
      sel = g;
      @(posedge clk);
      #1;
      run_pulse();
   endtask

   task automatic do_instr(logic [3:0] op, bit i5, bit b, string name);
      opcode = op;
      ir5 = i5;
      ben = b;
      push_fetch(sel + 2);
      push_exec(op, i5, b, sel + 2);
      run_queue(name);
   endtask

   task automatic do_pause(int hold, int cont_len);
      ctl_t c = dflt();
      opcode = OP_PAUSE;
      cont = 1'b0;
      push_fetch(sel + 2);
      c.ld_led = 1'b1;
      exp_q.push_back(c);
      run_queue("pause_entry");
      for (int i = 0; i < hold; i++) begin
         exp_q.push_back(dflt());
         check_cycle($sformatf("pause_hold[%0d]", i));
      end
      cont = 1'b1;
      for (int i = 0; i < cont_len; i++) begin
         exp_q.push_back(dflt());
         check_cycle($sformatf("pause_cont_hi[%0d]", i));
      end
      cont = 1'b0;
      exp_q.push_back(dflt());
      check_cycle("pause_cont_lo");
   endtask

   task automatic random_instrs(int n);
      for (int i = 0; i < n; i++) begin
         logic [3:0] op = 4'($urandom_range(0, 15));
         if (op == OP_PAUSE) do_pause($urandom_range(0, 5), $urandom_range(1, 4));
         else do_instr(op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $sformatf("rand_op%h", op));
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1, "bench did not finish");
   end

   initial begin
      // Instance 0: MEM_WAIT = 2, directed opcodes then random ones with Run toggling.
      start(0);
      do_instr(4'b0001, 1'b1, 1'b0, "add_imm");
      do_instr(4'b0001, 1'b0, 1'b0, "add_reg");
      do_instr(4'b0000, 1'b0, 1'b0, "br_not_taken");
      do_instr(4'b0000, 1'b0, 1'b1, "br_taken");
      do_instr(4'b0101, 1'b1, 1'b0, "and_imm");
      do_instr(4'b1001, 1'b0, 1'b0, "not");
      do_instr(4'b1100, 1'b0, 1'b0, "jmp");
      do_instr(4'b0100, 1'b0, 1'b0, "jsr");
      do_instr(4'b0110, 1'b0, 1'b0, "ldr");
      do_instr(4'b0111, 1'b0, 1'b0, "str");
      do_instr(4'b0011, 1'b0, 1'b0, "nop");
      do_pause(10, 2);
      do_instr(4'b0101, 1'b0, 1'b0, "and_after_pause");
      noisy_run = 1'b1;
      random_instrs(40);
      noisy_run = 1'b0;
      run = 1'b0;

      // Reset during the second write-strobe cycle of STR.
      opcode = 4'b0111;
      push_fetch(2);
      push_exec(4'b0111, 1'b0, 1'b0, 2);
      run_n(8, "str_pre_reset");
      rst[0] = 1'b1;
      check_cycle("str_second_we");
      exp_q.delete();
      exp_q.push_back(dflt());
      check_cycle("reset_mid_str");
      rst[0] = 1'b0;
      run_pulse();
      do_instr(4'b0001, 1'b1, 1'b0, "add_after_reset");

      // Instance 1: MEM_WAIT = 3.
      start(1);
      do_instr(4'b0110, 1'b0, 1'b0, "ldr_w3");
      do_instr(4'b0111, 1'b0, 1'b0, "str_w3");
      do_instr(4'b0000, 1'b0, 1'b1, "br_taken_w3");
      do_pause(3, 1);
      random_instrs(20);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/lc3_control_fsm.md
# lc3_control_fsm

Instruction-sequencing controller for the 16-bit LC-3-subset datapath. Moore FSM that walks fetch, decode and execute for each instruction. Drives every load, gate, mux-select and memory-strobe input of the datapath, and holds in a halted state until Run. Sits beside the datapath in the CPU top level and is the only source of its control signals.

## Interface
Parameters:
- MEM_WAIT, 2, cycles that each memory read/write state is held (1..15)

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- Run  in  1  start pulse; only effective in Halted
- Continue  in  1  debug handshake for PAUSE
- Opcode  in  4  IR[15:12]
- IR_5  in  1  IR[5], immediate select for ADD/AND
- BEN  in  1  branch-enable from datapath, valid the cycle after LD_BEN
- LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED  out  1 each  register loads
- GatePC, GateMDR, GateALU, GateMARMUX  out  1 each  bus drivers, at most one high per cycle
- PCMUX  out  2  0=bus, 1=ADDR1+ADDR2, 2=PC+1
- ADDR2MUX  out  2  0=sext off11, 1=sext off9, 2=sext off6, 3=zero
- ALUK  out  2  0=ADD, 1=AND, 2=NOT, 3=PASSA
- DRMUX, SR1MUX, SR2MUX, ADDR1MUX  out  1 each  DR: 0=IR[11:9], 1=R7. SR1: 0=IR[11:9], 1=IR[8:6]. SR2: 0=imm5, 1=reg. ADDR1: 0=SR1, 1=PC
- MIO_EN  out  1  1=MDR loads from memory, 0=from bus
- Mem_OE, Mem_WE  out  1 each  active-low SRAM strobes

## Operation
- Defaults in every state: all LD_*/Gate* 0, all selects 0, MIO_EN 0, Mem_OE 1, Mem_WE 1. Each state lists only what it changes.
- Halted: defaults. Run=1 goes to S18, otherwise stay.
- Fetch sequence:
  - S18: GatePC, LD_MAR, PCMUX=2, LD_PC. Next S33.
  - S33: Mem_OE=0, MIO_EN=1, LD_MDR. Held MEM_WAIT cycles, then S35.
  - S35: GateMDR, LD_IR. Next S32.
  - S32: LD_BEN. Decode on Opcode.
- Execute, by opcode:
  - 0001 ADD: S01, SR1MUX=1, SR2MUX=~IR_5, ALUK=0, GateALU, LD_REG, LD_CC. Next S18.
  - 0101 AND: S05, same as S01 but ALUK=1.
  - 1001 NOT: S09, SR1MUX=1, ALUK=2, GateALU, LD_REG, LD_CC. Next S18.
  - 0000 BR: S00. BEN=1 goes to S22, else S18.
    - S22: ADDR1MUX=1, ADDR2MUX=1, PCMUX=1, LD_PC. Next S18.
  - 1100 JMP: S12, SR1MUX=1, ADDR1MUX=0, ADDR2MUX=3, PCMUX=1, LD_PC. Next S18.
  - 0100 JSR: S04, DRMUX=1, GatePC, LD_REG. Then S21: ADDR1MUX=1, ADDR2MUX=0, PCMUX=1, LD_PC. Next S18.
  - 0110 LDR:
    - S06: SR1MUX=1, ADDR2MUX=2, GateMARMUX, LD_MAR.
    - S25: like S33, held MEM_WAIT cycles.
    - S27: GateMDR, LD_REG, LD_CC. Next S18.
  - 0111 STR:
    - S07: as S06.
    - S23: SR1MUX=0, ALUK=3, GateALU, LD_MDR.
    - S16: Mem_WE=0, held MEM_WAIT cycles. Next S18.
  - 1101 PAUSE: PauseIR1 with LD_LED for one cycle.
    - PauseIR1: stay while Continue=0; Continue=1 goes to PauseIR2.
    - PauseIR2: stay while Continue=1; Continue=0 goes to S18.
  - All other opcodes: S32 goes straight to S18 (NOP).
- Once running, Halted is re-entered only by Reset. Run is ignored outside Halted.

## Timing
- State register and 4-bit wait counter update on posedge Clk. All outputs decode combinationally from registered state only, so there is no input-to-output path.
- Reset=1 at a clock edge gives state Halted and counter 0. All outputs take default values the following cycle, even mid-instruction: a write strobe in S16 deasserts on the very next cycle.
- Wait counter:
  - Cleared on entry to S33, S25 and S16.
  - Increments each cycle in those states.
  - Exits when count = MEM_WAIT-1. MEM_WAIT=1 gives a single-cycle state.
- Fetch plus decode takes 3+MEM_WAIT cycles, measured S18 through S32.
- Instruction lengths, including fetch, with MEM_WAIT=2:
  - ADD/AND/NOT/JMP, and BR not taken: 6 cycles.
  - BR taken, JSR: 7 cycles.
  - LDR: 9 cycles. STR: 9 cycles.
- BEN is sampled in S00, one cycle after LD_BEN in S32.
- Continue is level-sampled every cycle. A Continue pulse must span at least one Clk edge to register.

## Test plan
- Reset, then Run pulse, MEM_WAIT=2 -> Halted cycle with Mem_OE=1. Next cycle S18 (GatePC, LD_MAR, LD_PC, PCMUX=2). Then Mem_OE=0 for exactly 2 cycles, then LD_IR, then LD_BEN.
- Opcode=0001, IR_5=1 -> exec cycle with SR1MUX=1, SR2MUX=0, ALUK=0, GateALU, LD_REG, LD_CC. Next cycle is S18. Same with IR_5=0 gives SR2MUX=1.
- Opcode=0000 with BEN=0 -> S18 directly after S00. With BEN=1 -> one cycle with PCMUX=1, ADDR1MUX=1, ADDR2MUX=1, LD_PC.
- LDR with MEM_WAIT=3 -> LD_MAR/GateMARMUX with ADDR2MUX=2, then Mem_OE=0 with MIO_EN=1 for exactly 3 cycles, then GateMDR+LD_REG+LD_CC.
- Opcode=1101 -> LD_LED one cycle, FSM holds 10 cycles with Continue=0. Continue=1 then 0 -> S18 the cycle after the fall.
- Reset asserted during second S16 cycle of STR -> next cycle Mem_WE=1 and all loads 0. A later Run restarts at S18.
- Throughout all scenarios: assert that at most one Gate* output is high in any cycle.
